// File: rtl/mux_arbiter4.sv
// Round-robin arbiter sharing one 4-bit 4:1 mux among four requesters.
// One grant at a time; one beat per cycle is registered onto Out.

module mux4_1_4bit (
   input  logic [1:0] S,
   input  logic [3:0] InA,
   input  logic [3:0] InB,
   input  logic [3:0] InC,
   input  logic [3:0] InD,
   output logic [3:0] Y
);
   always_comb begin
      case (S)
         2'd0:    Y = InA;
         2'd1:    Y = InB;
         2'd2:    Y = InC;
         default: Y = InD;
      endcase
   end
endmodule

module mux_arbiter4 #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Req,
   input  logic [3:0] Last,
   input  logic [3:0] InA,
   input  logic [3:0] InB,
   input  logic [3:0] InC,
   input  logic [3:0] InD,
   output logic [1:0] S,
   output logic [3:0] Gnt,
   output logic [3:0] Out,
   output logic       Valid,
   output logic       Busy
);
   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] LIM = 4'(HOLD_MAX - 1);

   state_t     r_state;
   logic [1:0] r_ptr;
   logic [3:0] r_cnt;
   logic [1:0] r_S;
   logic [3:0] r_Gnt;
   logic [3:0] r_Out;
   logic       r_Valid;

   logic [3:0] w_mux;
   logic [1:0] w_win;
   logic       w_beat;
   logic       w_done;

   mux4_1_4bit u_mux (
      .S   (r_S),
      .InA (InA),
      .InB (InB),
      .InC (InC),
      .InD (InD),
      .Y   (w_mux)
   );

   // Descending scan so the requester closest to ptr overrides later ones.
   always_comb begin
      w_win = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (Req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
      end
   end

   assign w_beat = Req[r_S];
   assign w_done = Last[r_S] || (r_cnt == LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_cnt   <= 4'd0;
         r_S     <= 2'd0;
         r_Gnt   <= 4'd0;
         r_Out   <= 4'd0;
         r_Valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_Valid <= 1'b0;
               if (|Req) begin
                  r_Gnt   <= 4'b0001 << w_win;
                  r_S     <= w_win;
                  r_cnt   <= 4'd0;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (w_beat) begin
                  r_Out   <= w_mux;
                  r_Valid <= 1'b1;
                  r_cnt   <= r_cnt + 4'd1;
               end else begin
                  r_Valid <= 1'b0;
               end
               // Release on last beat, beat limit, or withdrawal.
               if (!w_beat || w_done) begin
                  r_ptr   <= r_S + 2'd1;
                  r_Gnt   <= 4'd0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign S     = r_S;
   assign Gnt   = r_Gnt;
   assign Out   = r_Out;
   assign Valid = r_Valid;
   assign Busy  = |r_Gnt;
endmodule

// File: doc/mux_arbiter4.md
# mux_arbiter4

Round-robin arbiter that shares one `mux4_1_4bit` datapath among four 4-bit requesters. It grants one requester at a time, drives the mux select, and transfers one beat per cycle from the granted source to a registered output. The grant ends on the requester's last-beat flag, on request withdrawal, or on a per-grant beat limit. It sits between the four producer blocks and the single consumer of `Out`.

## Interface
- `HOLD_MAX`, default 4: maximum beats per grant before forced release; legal range 1..15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `Req`  in  4  request per requester; bit i corresponds to source i.
- `Last`  in  4  last-beat flag per requester; sampled only for the granted bit during a beat.
- `InA`, `InB`, `InC`, `InD`  in  4 each  source data for requesters 0..3.
- `S`  out  2  mux select, equal to the granted index; holds its last value when idle.
- `Gnt`  out  4  one-hot grant; all zero when idle.
- `Out`  out  4  registered transferred data.
- `Valid`  out  1  `Out` holds a beat transferred at the previous edge.
- `Busy`  out  1  high while in GRANT, identical to `|Gnt`.

## Operation
- Internal `mux4_1_4bit` instance, driven by `S` and `InA`..`InD`. Its output feeds the `Out` register.
- State: FSM {IDLE, GRANT}, round-robin pointer `ptr` (2 bits), beat counter `cnt` (4 bits).
- **IDLE:**
  - `Gnt` = 0.
  - If `Req` != 0 at an edge: the winner is the first set bit scanning `ptr`, `ptr`+1, … mod 4.
  - `Gnt` <= onehot(winner), `S` <= winner, `cnt` <= 0, go to GRANT.
  - If `Req` = 0: stay in IDLE.
- **GRANT, beat:** a beat occurs when `Req[S]` = 1 at an edge. Then `Out` <= mux output, `Valid` <= 1, `cnt` <= `cnt`+1.
- **GRANT, release:** release happens at the same edge as either condition below.
  - A beat with (`Last[S]` = 1 or `cnt` = `HOLD_MAX`-1).
  - `Req[S]` = 0, which is not a beat: `Valid` <= 0 and `Out` holds.
- **On release:**
  - `ptr` <= `S`+1 mod 4; wrap from 3 to 0.
  - `Gnt` <= 0, go to IDLE.
  - `S` holds.
- Any edge that is not a beat gives `Valid` <= 0. `Out` holds its last value.
- Requests from other sources during GRANT are ignored. They are considered at the next IDLE edge.
- `Last` on non-granted bits is ignored.
- `HOLD_MAX` = 1: every grant is exactly one beat.

## Timing
- Reset values: `S` = 0, `Gnt` = 0, `Out` = 0, `Valid` = 0, `Busy` = 0, `ptr` = 0, `cnt` = 0, state IDLE. Requester 0 has first priority after reset.
- Reset asserted mid-grant clears all state immediately (asynchronous), including a beat in flight. After `rst` falls, the first arbitration occurs at the next edge with `Req` != 0.
- Latency:
  - `Req` high before edge k → `Gnt`/`S` valid after edge k.
  - First beat sampled at edge k+1 → `Out`/`Valid` after edge k+1.
- Sustained rate: one beat per cycle within a grant.
- One mandatory IDLE cycle between consecutive grants, so a burst of n beats occupies n+2 edges from request to next arbitration.
- `Out`/`Valid` lag `Gnt` by one cycle. The final beat's `Valid` appears in the cycle where `Gnt` = 0.

## Test plan
- **Reset:** assert `rst` mid-burst (Gnt = 4'b0010, `Valid` = 1). Required: all outputs 0 immediately with no clock edge. After release with `Req` = 4'b1010, requester 1 wins (`ptr` = 0).
- **Single burst:** `Req` = 4'b0100, `InC` = 4'hA, `Last[2]` asserted on the 3rd beat. Required: `Gnt` = 4'b0100 and `S` = 2'b10 for 3 cycles; `Valid` high for 3 cycles with `Out` = 4'hA; then one cycle `Gnt` = 0.
- **Limit and rotation:** `HOLD_MAX` = 4, `Req` = 4'b1111 held, `Last` = 0. Required: grants in order 0, 1, 2, 3, 0, each exactly 4 beats, with one idle cycle between grants.
- **Round-robin fairness:** finish a grant to requester 1, then `Req` = 4'b0011. Required: requester 0 wins (scan order 2, 3, 0). The next grant after that goes to requester 1.
- **Withdrawal:** `Req[3]` drops after 2 beats of a grant (`HOLD_MAX` = 4). Required: exactly 2 `Valid` beats, release at the drop edge, `Out` holds the 2nd beat's value, `ptr` = 0.
- **Single-beat limit:** `HOLD_MAX` = 1, `Req` = 4'b0101. Required: alternating single-beat grants 0, 2, 0, 2; `Valid` pulses 1-0-1-0.
